// File: rtl/rtp_engine_up_master_pkg.sv
// Shared types and constants for the up_* bus master.
package rtp_engine_pkg;

  // Widest address/data the captured-command struct can hold.
  localparam int unsigned UP_ADDR_MAX = 32;
  localparam int unsigned UP_DATA_MAX = 64;

  // Read data returned on a timed-out transaction.
  localparam logic [31:0] UP_TIMEOUT_RDATA = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } up_state_t;

  typedef struct packed {
    logic                   write;
    logic [UP_ADDR_MAX-1:0] addr;
    logic [UP_DATA_MAX-1:0] wdata;
  } up_cmd_t;

endpackage

// File: rtl/rtp_engine_up_master_if.sv
// up_* register-access bus between an initiator (master) and a regmap (slave).
interface rtp_engine_up_master_if #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  up_wreq;
  logic [ADDR_WIDTH-1:0] up_waddr;
  logic [DATA_WIDTH-1:0] up_wdata;
  logic                  up_wack;
  logic                  up_rreq;
  logic [ADDR_WIDTH-1:0] up_raddr;
  logic [DATA_WIDTH-1:0] up_rdata;
  logic                  up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rack, up_rdata
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rack, up_rdata
  );

endinterface

// File: rtl/rtp_engine_up_master.sv
// Single-outstanding up_* bus master: command stream in, up_* request out,
// ack-completed (or timed-out) response stream back.
// Optional ack timeout enabled by defining RTP_ENGINE_UP_MASTER_TIMEOUT_EN.
module rtp_engine_up_master
  import rtp_engine_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 14,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  up_clk,
  input  logic                  up_rst,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,

  rtp_engine_up_master_if.master up
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > UP_ADDR_MAX) begin : g_bad_addr_width
    $error("ADDR_WIDTH out of range");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > UP_DATA_MAX) begin : g_bad_data_width
    $error("DATA_WIDTH out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  up_state_t state;
  up_cmd_t   cmd_q;

`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;
`else
  assign resp_error = 1'b0;
`endif

  // Only the direction bit is consumed after capture; address/data go
  // straight to the up_* registers so they can hold across transactions.
  logic unused_cmd_fields;
  assign unused_cmd_fields = ^{cmd_q.addr, cmd_q.wdata};

  // Transaction FSM; every output is registered here.
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      cmd_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_write  <= 1'b0;
      resp_rdata  <= '0;
      up.up_wreq  <= 1'b0;
      up.up_waddr <= '0;
      up.up_wdata <= '0;
      up.up_rreq  <= 1'b0;
      up.up_raddr <= '0;
`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
      resp_error  <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // Request is raised on acceptance so it is high for the whole ISSUE cycle.
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cmd_q     <= '{write: cmd_write,
                           addr:  UP_ADDR_MAX'(cmd_addr),
                           wdata: UP_DATA_MAX'(cmd_wdata)};
            state     <= ISSUE;
            if (cmd_write) begin
              up.up_wreq  <= 1'b1;
              up.up_waddr <= cmd_addr;
              up.up_wdata <= cmd_wdata;
            end else begin
              up.up_rreq  <= 1'b1;
              up.up_raddr <= cmd_addr;
            end
          end
        end

        ISSUE: begin
          up.up_wreq <= 1'b0;
          up.up_rreq <= 1'b0;
          state      <= WAIT;
`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
          tmo_cnt    <= '0;
`endif
        end

        WAIT: begin
          if (cmd_q.write ? up.up_wack : up.up_rack) begin
            resp_valid <= 1'b1;
            resp_write <= cmd_q.write;
            resp_rdata <= cmd_q.write ? '0 : up.up_rdata;
`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
            resp_error <= 1'b0;
`endif
            state      <= RESP;
          end
`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
          // Limit is hit on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle ack wins above.
          else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt    <= tmo_cnt + 16'd1;
            resp_valid <= 1'b1;
            resp_write <= cmd_q.write;
            resp_rdata <= DATA_WIDTH'(UP_TIMEOUT_RDATA);
            resp_error <= 1'b1;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
`endif
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtp_engine_up_master.sv
// Scoreboard bench for rtp_engine_up_master with a small regmap responder.
// Build with RTP_ENGINE_UP_MASTER_TIMEOUT_EN defined to exercise the timeout.
`timescale 1ns/1ps
module tb_rtp_engine_up_master;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_write;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;

  always #5 clk = ~clk;

  rtp_engine_up_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_bus ();

  rtp_engine_up_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .up_clk     (clk),
    .up_rst     (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_write (resp_write),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .up         (u_bus)
  );

  // ---------------- bookkeeping ----------------
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_acc = 0;
  int unsigned n_req = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- regmap responder ----------------
  logic          silent = 1'b0;
  int unsigned   lat = 1;
  logic          rsp_wack = 1'b0, rsp_rack = 1'b0;
  logic [DW-1:0] rsp_rdata = '0;
  logic          st_wack = 1'b0, st_rack = 1'b0;
  logic [DW-1:0] st_rdata = '0;
  logic [DW-1:0] rm_mem [16] = '{default: '0};
  int unsigned   pend_cnt = 0;
  logic          pend_w = 1'b0;
  logic [AW-1:0] pend_a = '0;
  logic [DW-1:0] pend_d = '0;

  assign u_bus.up_wack  = rsp_wack | st_wack;
  assign u_bus.up_rack  = rsp_rack | st_rack;
  assign u_bus.up_rdata = rsp_rack ? rsp_rdata : st_rdata;

  always @(posedge clk) begin
    logic          do_fire;
    logic          fw;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    do_fire = 1'b0;
    fw = 1'b0; fa = '0; fd = '0;
    rsp_wack <= 1'b0;
    rsp_rack <= 1'b0;
    if (pend_cnt == 1) begin
      do_fire = 1'b1; fw = pend_w; fa = pend_a; fd = pend_d;
    end
    if (pend_cnt != 0) pend_cnt <= pend_cnt - 1;
    if (!silent && (u_bus.up_wreq || u_bus.up_rreq)) begin
      if (lat <= 1) begin
        do_fire = 1'b1;
        fw = u_bus.up_wreq;
        fa = u_bus.up_wreq ? u_bus.up_waddr : u_bus.up_raddr;
        fd = u_bus.up_wdata;
      end else begin
        pend_cnt <= lat - 1;
        pend_w   <= u_bus.up_wreq;
        pend_a   <= u_bus.up_wreq ? u_bus.up_waddr : u_bus.up_raddr;
        pend_d   <= u_bus.up_wdata;
      end
    end
    if (do_fire) begin
      if (fw) begin
        if (fa != 0) rm_mem[fa[3:0]] <= fd;
        rsp_wack <= 1'b1;
      end else begin
        rsp_rdata <= (fa == 0) ? 32'h1 : rm_mem[fa[3:0]];
        rsp_rack  <= 1'b1;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic          w;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  logic          last_w = 1'b0;
  logic [AW-1:0] last_a = '0;
  logic [DW-1:0] last_d = '0;

  // Address 0 is a read-only VERSION register holding 1.
  function automatic exp_t model(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.w = w;
    e.err = 1'b0;
`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
    if (silent) begin
      e.rdata = 32'hDEAD_DEAD;
      e.err = 1'b1;
      return e;
    end
`endif
    if (w) begin
      e.rdata = '0;
      if (a != 0) ref_mem[a[3:0]] = d;
    end else begin
      e.rdata = (a == 0) ? 32'h1 : ref_mem[a[3:0]];
    end
    return e;
  endfunction

  // Monitor: samples just after the falling edge, pops on every response handshake.
  initial begin
    logic          pv, pr, pw, pe, prev_wreq, prev_rreq;
    logic [DW-1:0] pd;
    exp_t          e;
    pv = 0; pr = 0; pw = 0; pe = 0; pd = '0; prev_wreq = 0; prev_rreq = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pv = 0; prev_wreq = 0; prev_rreq = 0;
      end else begin
        if (pv && !pr)
          check("resp_hold", {29'd0, resp_valid, resp_write, resp_error, resp_rdata},
                {29'd0, 1'b1, pw, pe, pd});
        if (resp_valid && resp_ready) begin
          if (sb.size() == 0) begin
            check("resp_unexpected", {62'd0, resp_valid, resp_ready}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("resp_write", {63'd0, resp_write}, {63'd0, e.w});
            check("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
            check("resp_error", {63'd0, resp_error}, {63'd0, e.err});
          end
        end
        if (u_bus.up_wreq) begin
          n_req++;
          check("wreq_pulse", {63'd0, prev_wreq}, 64'd0);
          check("wreq_kind", {63'd0, last_w}, 64'd1);
          check("wreq_addr_data", {18'd0, u_bus.up_waddr, u_bus.up_wdata}, {18'd0, last_a, last_d});
        end
        if (u_bus.up_rreq) begin
          n_req++;
          check("rreq_pulse", {63'd0, prev_rreq}, 64'd0);
          check("rreq_kind", {63'd0, last_w}, 64'd0);
          check("rreq_addr", {50'd0, u_bus.up_raddr}, {50'd0, last_a});
        end
        prev_wreq = u_bus.up_wreq;
        prev_rreq = u_bus.up_rreq;
        pv = resp_valid; pr = resp_ready; pw = resp_write; pe = resp_error; pd = resp_rdata;
      end
    end
  end

  // Random backpressure, driven well away from the sampling point.
  logic rr_rand = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned guard = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        check("cmd_accept_timeout", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b0;
        return;
      end
    end
    last_w = w; last_a = a; last_d = d;
    sb.push_back(model(w, a, d));
    n_acc++;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_addr  = AW'($urandom());
    cmd_wdata = $urandom();
  endtask

  task automatic wait_drain();
    int unsigned guard = 0;
    while ((sb.size() != 0 || !cmd_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain", {63'd0, cmd_ready}, 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {58'd0, cmd_ready, resp_valid, resp_write, resp_error,
          u_bus.up_wreq, u_bus.up_rreq}, 64'd0);
    check({name, "_bus"}, {4'd0, u_bus.up_waddr, u_bus.up_wdata, u_bus.up_raddr}, 64'd0);
    check({name, "_rdata"}, {32'd0, resp_rdata}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int unsigned k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", {63'd0, cmd_ready}, 64'd1);

    // Directed write with latency checks against the acceptance cycle.
    lat = 1;
    send_cmd(1'b1, 14'h2, 32'h1);
    check("lat_wreq_n1", {63'd0, u_bus.up_wreq}, 64'd1);
    @(negedge clk);
    check("lat_n2", {62'd0, u_bus.up_wreq, resp_valid}, 64'd0);
    @(negedge clk);
    check("lat_resp_n3", {63'd0, resp_valid}, 64'd1);
    @(negedge clk);
    check("lat_ready_n4", {62'd0, cmd_ready, resp_valid}, 64'd2);
    send_cmd(1'b0, 14'h2, '0);
    send_cmd(1'b0, 14'h0, '0);
    wait_drain();

    // Back-to-back with response backpressure.
    resp_ready = 1'b0;
    send_cmd(1'b1, 14'h5, 32'hA5A5_0F0F);
    fork
      send_cmd(1'b0, 14'h5, '0);
      begin
        int unsigned g = 0;
        while (!resp_valid && g < 50) begin @(negedge clk); g++; end
        check("b2b_resp_seen", {63'd0, resp_valid}, 64'd1);
        repeat (5) begin
          @(negedge clk);
          check("b2b_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("b2b_cmd_ready_back", {63'd0, cmd_ready}, 64'd1);
      end
    join
    wait_drain();

    // Stray acks: rack in IDLE, rack during ISSUE, wack during a read WAIT.
    st_rdata = 32'h5555_AAAA;
    st_rack = 1'b1;
    @(negedge clk);
    st_rack = 1'b0;
    check("stray_idle", {62'd0, cmd_ready, resp_valid}, 64'd2);
    lat = 4;
    send_cmd(1'b0, 14'h0, '0);
    st_rack = 1'b1;
    @(negedge clk);
    st_rack = 1'b0;
    st_wack = 1'b1;
    @(negedge clk);
    st_wack = 1'b0;
    check("stray_wait_no_resp", {63'd0, resp_valid}, 64'd0);
    wait_drain();

    // Silent responder.
    silent = 1'b1;
    send_cmd(1'b0, 14'h0, '0);
`ifdef RTP_ENGINE_UP_MASTER_TIMEOUT_EN
    k = 1;
    while (!resp_valid && k < 50) begin @(negedge clk); k++; end
    check("tmo_latency", 64'(k), 64'd10);
    silent = 1'b0;
    st_rdata = 32'h0000_0005;
    st_rack = 1'b1;
    @(negedge clk);
    st_rack = 1'b0;
    wait_drain();
    st_rack = 1'b1;
    @(negedge clk);
    st_rack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("late_ack_ignored", {62'd0, cmd_ready, resp_valid}, 64'd2);
    end
`else
    k = 0;
    repeat (40) begin
      @(negedge clk);
      check("wait_hold", {62'd0, resp_valid, cmd_ready}, 64'd0);
    end
    st_rdata = 32'h1;
    st_rack = 1'b1;
    @(negedge clk);
    st_rack = 1'b0;
    silent = 1'b0;
    wait_drain();
`endif

    // Reset during WAIT; the responder's ack lands afterwards.
    lat = 6;
    send_cmd(1'b0, 14'h3, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("post_reset_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    lat = 1;
    send_cmd(1'b1, 14'h3, 32'h1234_5678);
    send_cmd(1'b0, 14'h3, '0);
    wait_drain();

    // Randomized traffic with random latency and backpressure.
    rr_rand = 1'b1;
    repeat (60) begin
      lat = $urandom_range(1, 4);
      send_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom());
    end
    wait_drain();
    rr_rand = 1'b0;
    @(negedge clk);
    resp_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("req_count", 64'(n_req), 64'(n_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtp_engine_up_master.md
Name: rtp_engine_up_master

Overview:
- Initiator side of the up_* register-access bus: accepts single read/write commands on a valid/ready stream and drives up_wreq/up_waddr/up_wdata or up_rreq/up_raddr toward a regmap responder.
- Waits for up_wack/up_rack and returns status and read data on a response stream.
- Sits between an on-chip sequencer (RTP start/stop scripting, self-test) and any up_* regmap, e.g. the RTP engine regmap.

Parameters:
- ADDR_WIDTH, 14, up_* address width.
- DATA_WIDTH, 32, up_* data width.
- TIMEOUT_CYCLES, 256, cycles to wait for an ack before abort; legal 2..65535; used only with the optional feature.

Ports:
- up_clk  in  1  single clock for all logic
- up_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when valid&ready
- resp_write  out  1  echoes cmd_write of the completed command
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes
- resp_error  out  1  1 = transaction timed out
- up_wreq  out  1  write request, one-cycle pulse
- up_waddr  out  ADDR_WIDTH  write address
- up_wdata  out  DATA_WIDTH  write data
- up_wack  in  1  write acknowledge
- up_rreq  out  1  read request, one-cycle pulse
- up_raddr  out  ADDR_WIDTH  read address
- up_rdata  in  DATA_WIDTH  read data, valid with up_rack
- up_rack  in  1  read acknowledge

Behaviour:
- Clock and reset: one clock, up_clk. Reset up_rst is synchronous and active-high.
- Reset values: all outputs 0, including cmd_ready, resp_*, up_wreq, up_rreq, addresses and data. State is IDLE.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, register addr/data/write and go to ISSUE.
  - ISSUE: assert up_wreq (write) or up_rreq (read) for exactly this one cycle, with address/data stable. Go to WAIT.
  - WAIT: wait for the matching ack.
    - up_wack for a write: capture resp_rdata=0.
    - up_rack for a read: capture resp_rdata=up_rdata in the same cycle.
    - On either ack, set resp_valid=1 and go to RESP.
    - The non-matching ack is ignored.
  - RESP: hold resp_* stable while resp_valid=1. When resp_ready=1, clear resp_valid and go to IDLE.
- cmd_ready is 0 outside IDLE: one outstanding transaction, no pipelining.
- Latency with a one-cycle responder and resp_ready=1:
  - command accepted at cycle N; req high at N+1; ack at N+2; resp_valid at N+3; cmd_ready high again at N+4.
- up_waddr/up_wdata/up_raddr hold their last driven value after the transaction. Only the req lines pulse.
- Stray acks (in IDLE, ISSUE, RESP, or a late ack after timeout) are ignored and do not change state or data.
- An ack arriving in the same cycle as req (zero-latency responder) is not legal and is ignored. The master samples acks only in WAIT.
- Reset mid-operation (any state) returns to IDLE immediately. The in-flight response is discarded and no resp_valid is produced.
- resp_error is 0 for every ack-completed transaction.

Optional Feature:
- Macro: RTP_ENGINE_UP_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without an ack: resp_valid=1, resp_error=1, resp_rdata=32'hDEAD_DEAD (truncated/zero-extended to DATA_WIDTH), go to RESP.
  - An ack in the same cycle the counter hits the limit wins: normal completion, resp_error=0.
- Undefined:
  - No counter; WAIT lasts until an ack arrives.
  - resp_error is tied to 0.

Decomposition:
- Package rtp_engine_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the constant UP_TIMEOUT_RDATA = 32'hDEAD_DEAD;
  - a packed command struct {write, addr, wdata}.
- No sub-module. Counter and FSM stay in one module, with the timeout logic inside the macro guard.

Test Plan:
- Write addr 14'h2, data 32'h1 to an rtp_engine regmap model; resp_ready=1 -> up_wreq is a single pulse at N+1; resp_valid at N+3 with resp_write=1, resp_error=0, resp_rdata=0; a regmap read-back of 14'h2 returns 1.
- Read addr 14'h0 from a model returning VERSION=1 -> up_rreq is a single pulse; resp_rdata=32'h1, resp_write=0.
- Back-to-back commands with cmd_valid held high and resp_ready=0 for 5 cycles -> cmd_ready stays 0 and resp_* stay stable; the second command is accepted the cycle after resp_ready rises.
- Stray up_rack during IDLE and up_wack during a read WAIT -> no state change; the read completes only on up_rack.
- With RTP_ENGINE_UP_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, responder silent -> resp_error=1, resp_rdata=32'hDEAD_DEAD after 8 WAIT cycles; an ack arriving later is ignored. Without the macro, the same stimulus keeps the block in WAIT indefinitely.
- up_rst asserted during WAIT, then the ack arrives -> all outputs 0, no resp_valid; the next command completes normally.
